// File: rtl/sha256_axil_pkg.sv
// rtl/sha256_axil_pkg.sv - response codes, control-register constants and channel state types
// Ports: none (package). Optional feature macro used by the top: SHA_AXIL_SLVERR_EN.
package sha256_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word slot of the control register and the bit inside it that fires start_o.
  localparam int REG_CTRL  = 0;
  localparam int START_BIT = 0;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/sha256_axil_regs_if.sv
// rtl/sha256_axil_regs_if.sv - AXI4-Lite bus bundle between the IP wrapper and the register file
// Ports: AW/W/B/AR/R channel signals; modport master drives requests, modport slave answers them.
interface sha256_axil_regs_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  import sha256_axil_pkg::*;

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/sha256_axil_wstrb_merge.sv
// rtl/sha256_axil_wstrb_merge.sv - combinational byte-lane merge of old register data with WDATA under WSTRB
// Ports: old_data, wdata, wstrb in; merged out (strobed lanes from wdata, others from old_data).
module sha256_axil_wstrb_merge
  import sha256_axil_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/sha256_axil_regs.sv
// rtl/sha256_axil_regs.sv - AXI4-Lite register file for the SHA-256 hasher with start pulse on reg0 bit0
// Ports: S_AXI_ACLK, S_AXI_ARESET (sync, active high), s_axi (slave modport of sha256_axil_regs_if),
//        regs_o (reg k at [32k+31:32k]), start_o (one-cycle pulse).
// Macro SHA_AXIL_SLVERR_EN: when defined, accesses to unimplemented slots answer SLVERR instead of OKAY.
module sha256_axil_regs
  import sha256_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  sha256_axil_regs_if.slave                      s_axi,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_o,
  output logic                                   start_o
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic [DW-1:0] regs [NUM_REGS];

  // Write channel state
  wr_state_t                     wr_state;
  logic                          aw_held, w_held;
  logic                          awready_q, wready_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [DW-1:0]                 wdata_q;
  logic [SW-1:0]                 wstrb_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
  logic                          start_q;

  // Read channel state
  rd_state_t     rd_state;
  logic          arready_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic             aw_fire, w_fire, ar_fire, commit;
  logic             aw_held_n, w_held_n;
  logic             wr_hit, rd_hit, start_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DW-1:0]    wr_old, wr_new, rd_val;
  logic [1:0]       wr_resp, rd_resp;

  always_comb begin
    aw_fire = s_axi.S_AXI_AWVALID && awready_q;
    w_fire  = s_axi.S_AXI_WVALID && wready_q;
    ar_fire = s_axi.S_AXI_ARVALID && arready_q;

    // A held pair only commits once the previous B handshake has finished.
    commit  = aw_held && w_held && (wr_state == W_IDLE);

    // Capture and commit are mutually exclusive per channel (READY = !held).
    aw_held_n = commit ? 1'b0 : (aw_held || aw_fire);
    w_held_n  = commit ? 1'b0 : (w_held || w_fire);

    // Byte address bits [1:0] do not take part in the decode.
    wr_idx = awaddr_q[C_S_AXI_ADDR_WIDTH-1:2];
    rd_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    wr_hit = 32'(wr_idx) < NUM_REGS;
    rd_hit = 32'(rd_idx) < NUM_REGS;

    wr_old = '0;
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_idx == IDX_W'(k)) wr_old = regs[k];
      if (rd_hit && (rd_idx == IDX_W'(k))) rd_val = regs[k];
    end

    start_hit = wr_hit && (wr_idx == IDX_W'(REG_CTRL)) &&
                wstrb_q[START_BIT/8] && wdata_q[START_BIT];

    wr_resp = RESP_OKAY;
    rd_resp = RESP_OKAY;
`ifdef SHA_AXIL_SLVERR_EN
    if (!wr_hit) wr_resp = RESP_SLVERR;
    if (!rd_hit) rd_resp = RESP_SLVERR;
`endif
  end

  sha256_axil_wstrb_merge #(
    .DATA_W(DW)
  ) u_wstrb_merge (
    .old_data(wr_old),
    .wdata   (wdata_q),
    .wstrb   (wstrb_q),
    .merged  (wr_new)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      start_q   <= 1'b0;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      awready_q <= !aw_held_n;
      wready_q  <= !w_held_n;
      if (aw_fire) awaddr_q <= s_axi.S_AXI_AWADDR;
      if (w_fire) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      case (wr_state)
        W_IDLE: begin
          if (commit) begin
            // Out-of-range slots match no k, so the write is dropped.
            for (int k = 0; k < NUM_REGS; k++) begin
              if (wr_hit && (wr_idx == IDX_W'(k))) regs[k] <= wr_new;
            end
            start_q  <= start_hit;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // rd_val is taken from the pre-commit register array, so a read landing
  // in the commit cycle of a write to the same slot returns the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_fire) begin
            rdata_q   <= rd_val;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rd_state  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[DW*k +: DW] = regs[k];
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign start_o             = start_q;

  // Protection bits and sub-word address bits have no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         awaddr_q[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_sha256_axil_regs.sv
// tb/tb_sha256_axil_regs.sv - scoreboard bench for sha256_axil_regs with a word-array reference model
module tb_sha256_axil_regs;

`ifdef SHA_AXIL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] regs_o;
  logic         start_o;

  sha256_axil_regs_if #(.ADDR_W(6), .DATA_W(32)) axi ();

  sha256_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (axi),
    .regs_o      (regs_o),
    .start_o     (start_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] model [4];
  int exp_starts = 0;
  int seen_starts = 0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  int b_seen = 0, r_seen = 0;
  int b_rise_cyc = 0, r_rise_cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no DUT handshake within bound, required one", name);
  endtask

  // Reference model: plain array of words plus the slot/strobe rules.
  function automatic logic [1:0] exp_resp(input logic [5:0] a);
    int idx = int'(a[5:2]);
    return (idx >= 4 && SLVERR_EN) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int idx = int'(a[5:2]);
    return (idx < 4) ? model[idx] : 32'h0;
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[5:2]);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      if (idx == 0 && s[0] && d[0]) exp_starts++;
    end
  endtask

  task automatic check_regs(input string name);
    check(name, regs_o, {model[3], model[2], model[1], model[0]});
  endtask

  // Monitor: pops the scoreboard at each B/R handshake and watches stalls.
  initial begin
    logic pb_valid, pb_ready, pr_valid, pr_ready, p_start;
    logic [1:0] pb_resp;
    logic [33:0] pr_data;
    pb_valid = 0; pb_ready = 0; pr_valid = 0; pr_ready = 0; p_start = 0;
    pb_resp = 0; pr_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb_valid = 0; pr_valid = 0; p_start = 0;
      end else begin
        if (axi.S_AXI_BVALID && !pb_valid) b_rise_cyc = cyc;
        if (axi.S_AXI_RVALID && !pr_valid) r_rise_cyc = cyc;
        if (pb_valid && !pb_ready) begin
          check("b_stall_valid", axi.S_AXI_BVALID, 1'b1);
          check("b_stall_resp", axi.S_AXI_BRESP, pb_resp);
        end
        if (pr_valid && !pr_ready) begin
          check("r_stall_valid", axi.S_AXI_RVALID, 1'b1);
          check("r_stall_data", {axi.S_AXI_RRESP, axi.S_AXI_RDATA}, pr_data);
        end
        if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
          if (exp_b.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b_unexpected: got BRESP %0h, required no response", axi.S_AXI_BRESP);
          end else check("bresp", axi.S_AXI_BRESP, exp_b.pop_front());
          b_seen++;
        end
        if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
          if (exp_r.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL r_unexpected: got RDATA %0h, required no response", axi.S_AXI_RDATA);
          end else check("rresp_rdata", {axi.S_AXI_RRESP, axi.S_AXI_RDATA}, exp_r.pop_front());
          r_seen++;
        end
        if (start_o) begin
          seen_starts++;
          check("start_width", p_start, 1'b0);
        end
        pb_valid = axi.S_AXI_BVALID; pb_ready = axi.S_AXI_BREADY; pb_resp = axi.S_AXI_BRESP;
        pr_valid = axi.S_AXI_RVALID; pr_ready = axi.S_AXI_RREADY;
        pr_data  = {axi.S_AXI_RRESP, axi.S_AXI_RDATA};
        p_start  = start_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [5:0] a, input int dly, output int hs);
    repeat (dly) tick();
    axi.S_AXI_AWADDR = a;
    axi.S_AXI_AWVALID = 1'b1;
    hs = -1;
    for (int t = 0; t < 40 && hs < 0; t++) begin
      @(negedge clk);
      if (axi.S_AXI_AWREADY) hs = cyc;
      tick();
    end
    axi.S_AXI_AWVALID = 1'b0;
    if (hs < 0) timeout("aw_handshake");
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
    repeat (dly) tick();
    axi.S_AXI_WDATA = d;
    axi.S_AXI_WSTRB = s;
    axi.S_AXI_WVALID = 1'b1;
    hs = -1;
    for (int t = 0; t < 40 && hs < 0; t++) begin
      @(negedge clk);
      if (axi.S_AXI_WREADY) hs = cyc;
      tick();
    end
    axi.S_AXI_WVALID = 1'b0;
    if (hs < 0) timeout("w_handshake");
  endtask

  task automatic do_ar(input logic [5:0] a, input int dly, output int hs);
    repeat (dly) tick();
    axi.S_AXI_ARADDR = a;
    axi.S_AXI_ARVALID = 1'b1;
    hs = -1;
    for (int t = 0; t < 40 && hs < 0; t++) begin
      @(negedge clk);
      if (axi.S_AXI_ARREADY) hs = cyc;
      tick();
    end
    axi.S_AXI_ARVALID = 1'b0;
    if (hs < 0) timeout("ar_handshake");
  endtask

  task automatic wait_b(input int target);
    for (int t = 0; t < 60 && b_seen < target; t++) tick();
    if (b_seen < target) timeout("b_response");
  endtask

  task automatic wait_r(input int target);
    for (int t = 0; t < 60 && r_seen < target; t++) tick();
    if (r_seen < target) timeout("r_response");
  endtask

  task automatic write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int aw_dly, input int w_dly);
    int ha, hw, nb;
    nb = b_seen + 1;
    exp_b.push_back(exp_resp(a));
    fork
      do_aw(a, aw_dly, ha);
      do_w(d, s, w_dly, hw);
    join
    model_write(a, d, s);
    wait_b(nb);
    check("b_latency", b_rise_cyc - ((ha > hw) ? ha : hw), 2);
  endtask

  task automatic read(input logic [5:0] a, input int dly);
    int h, nr;
    nr = r_seen + 1;
    exp_r.push_back({exp_resp(a), model_read(a)});
    do_ar(a, dly, h);
    wait_r(nr);
    check("r_latency", r_rise_cyc - h, 1);
  endtask

  initial begin
    int ha, hw, h, nb, nr, starts_before;
    logic [31:0] old1;
    axi.S_AXI_AWADDR = 0; axi.S_AXI_AWPROT = 0; axi.S_AXI_AWVALID = 0;
    axi.S_AXI_WDATA = 0; axi.S_AXI_WSTRB = 0; axi.S_AXI_WVALID = 0;
    axi.S_AXI_BREADY = 1;
    axi.S_AXI_ARADDR = 0; axi.S_AXI_ARPROT = 0; axi.S_AXI_ARVALID = 0;
    axi.S_AXI_RREADY = 1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", axi.S_AXI_AWREADY, 1'b0);
    check("rst_wready", axi.S_AXI_WREADY, 1'b0);
    check("rst_arready", axi.S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", axi.S_AXI_BVALID, 1'b0);
    check("rst_rvalid", axi.S_AXI_RVALID, 1'b0);
    check("rst_resp", {axi.S_AXI_BRESP, axi.S_AXI_RRESP}, 4'h0);
    check("rst_rdata", axi.S_AXI_RDATA, 32'h0);
    check("rst_start", start_o, 1'b0);
    check("rst_regs", regs_o, 128'h0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);

    // Sequential write then read
    for (int i = 0; i < 4; i++) write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) read(6'(4 * i), 0);
    check("seq_regs", regs_o, {32'd4, 32'd3, 32'd2, 32'd1});
    check("seq_start_count", seen_starts, 1);

    // Channel ordering: W first, AW first, same cycle
    write(6'h04, 32'hA5A5_0001, 4'hF, 1, 0);
    write(6'h04, 32'hA5A5_0001, 4'hF, 0, 1);
    write(6'h04, 32'hA5A5_0001, 4'hF, 0, 0);
    read(6'h04, 0);

    // Byte strobes
    write(6'h08, 32'h1122_3344, 4'hF, 0, 0);
    write(6'h08, 32'hFFFF_FFFF, 4'b0101, 0, 0);
    read(6'h08, 0);
    check("strobe_merge", regs_o[95:64], 32'h11FF_33FF);

    // Write backpressure with a second write queued behind the pending B
    old1 = model[1];
    axi.S_AXI_BREADY = 1'b0;
    nb = b_seen;
    exp_b.push_back(exp_resp(6'h08));
    fork
      do_aw(6'h08, 0, ha);
      do_w(32'hCAFE_0002, 4'hF, 0, hw);
    join
    model_write(6'h08, 32'hCAFE_0002, 4'hF);
    for (int t = 0; t < 20 && !axi.S_AXI_BVALID; t++) tick();
    exp_b.push_back(exp_resp(6'h04));
    fork
      do_aw(6'h04, 0, ha);
      do_w(32'hBEEF_0003, 4'hF, 0, hw);
    join
    repeat (5) begin
      tick();
      check("bp_no_commit", regs_o[63:32], old1);
    end
    axi.S_AXI_BREADY = 1'b1;
    wait_b(nb + 2);
    model_write(6'h04, 32'hBEEF_0003, 4'hF);
    check_regs("bp_regs_after");

    // Read backpressure
    axi.S_AXI_RREADY = 1'b0;
    nr = r_seen;
    exp_r.push_back({exp_resp(6'h08), model_read(6'h08)});
    do_ar(6'h08, 0, h);
    repeat (5) begin
      @(negedge clk);
      check("bp_arready_low", axi.S_AXI_ARREADY, 1'b0);
      tick();
    end
    axi.S_AXI_RREADY = 1'b1;
    wait_r(nr + 1);

    // Unimplemented slot
    write(6'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    read(6'h10, 0);
    check_regs("oob_regs");

    // Read in the commit cycle of a write to the same slot returns the old value
    fork
      write(6'h04, 32'h1234_5678, 4'hF, 0, 0);
      read(6'h04, 1);
    join
    check_regs("same_cycle_regs");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 23));
      if ($urandom_range(0, 1) == 1)
        write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        read(a, $urandom_range(0, 2));
      check_regs("rand_regs");
    end

    // Reset with AW held and no W
    starts_before = seen_starts;
    do_aw(6'h00, 0, ha);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    tick();
    check("rst_mid_awready", axi.S_AXI_AWREADY, 1'b1);
    check("rst_mid_bvalid", axi.S_AXI_BVALID, 1'b0);
    check("rst_mid_regs", regs_o, 128'h0);
    do_w(32'h0000_0001, 4'hF, 0, hw);
    repeat (5) tick();
    check("rst_aw_discarded", axi.S_AXI_BVALID, 1'b0);
    check("rst_no_start", seen_starts, starts_before);
    nb = b_seen + 1;
    exp_b.push_back(exp_resp(6'h00));
    do_aw(6'h00, 0, ha);
    model_write(6'h00, 32'h0000_0001, 4'hF);
    wait_b(nb);
    check_regs("rst_recover_regs");
    read(6'h00, 0);

    repeat (3) tick();
    check("b_queue_empty", exp_b.size(), 0);
    check("r_queue_empty", exp_r.size(), 0);
    check("start_count", seen_starts, exp_starts);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
